axi_rr_arbiter: RTL and testbench

- Parametrised, registered N-way arbiter for AXI master-side channel muxing.
- Supports two priority modes, selected at runtime:
  - round-robin with a rotating pointer;
  - fixed priority, where index 0 is highest.
- A grant is held until the owning transaction signals completion.
- An optional hold-timeout forces release from a stuck owner.
- Sits in front of the AW/AR address muxes and the W-channel ownership logic.

---
 rtl/axi_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_axi_rr_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_arbiter.sv
// Registered N-way arbiter for AXI channel muxing with round-robin/fixed priority,
// grant held until done, and an optional hold timeout that forces release.
module axi_rr_arbiter #(
  parameter int unsigned REQ_WIDTH = 4,
  parameter int unsigned IDX_WIDTH = $clog2(REQ_WIDTH),
  parameter int unsigned MAX_HOLD  = 0,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [REQ_WIDTH-1:0] req,
  input  logic                 fixed_pri_en,
  input  logic                 done,
  output logic [REQ_WIDTH-1:0] gnt,
  output logic [IDX_WIDTH-1:0] gnt_idx,
  output logic                 gnt_vld,
  output logic [IDX_WIDTH-1:0] ptr,
  output logic                 timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e               state_q, state_d;
  logic [REQ_WIDTH-1:0] gnt_q, gnt_d;
  logic [IDX_WIDTH-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] hold_q, hold_d;

  logic                 tmo_hit;
  logic                 release_grant;
  logic                 win_found;
  logic [IDX_WIDTH-1:0] win_idx;
  int unsigned          cand;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    tmo_hit = 1'b0;
    if (MAX_HOLD != 0) begin
      tmo_hit = (state_q == GRANT) && !done && (hold_q == CNT_WIDTH'(MAX_HOLD - 1));
    end
    release_grant = (state_q == GRANT) && (done || tmo_hit);

    ptr_d = ptr_q;
    if (release_grant && !fixed_pri_en) begin
      ptr_d = (gnt_idx_q == IDX_WIDTH'(REQ_WIDTH - 1)) ? '0 : gnt_idx_q + 1'b1;
    end

    // Search starts from the already-updated pointer so a release re-arbitrates without a bubble.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < REQ_WIDTH; i++) begin
      cand = fixed_pri_en ? i : 32'(ptr_d) + i;
      if (cand >= REQ_WIDTH) cand = cand - REQ_WIDTH;
      if (!win_found && req[IDX_WIDTH'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_WIDTH'(cand);
      end
    end

    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d   = GRANT;
          gnt_d     = REQ_WIDTH'(1) << win_idx;
          gnt_idx_d = win_idx;
          hold_d    = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          timeout_d = tmo_hit;
          if (win_found) begin
            gnt_d     = REQ_WIDTH'(1) << win_idx;
            gnt_idx_d = win_idx;
            hold_d    = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt     = gnt_q;
    gnt_idx = gnt_idx_q;
    gnt_vld = |gnt_q;
    ptr     = ptr_q;
    timeout = timeout_q;
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Scoreboard bench: two arbiters (no timeout / MAX_HOLD=8) share stimulus and are
// compared each cycle against a queue-fed behavioural model of the arbitration rules.
module tb_axi_rr_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] req_i;
  logic       fix_i;
  logic       done_i;

  logic [3:0] gnt0, gnt8;
  logic [1:0] idx0, idx8, ptr0, ptr8;
  logic       vld0, vld8, tmo0, tmo8;

  always #5 clk = ~clk;

  axi_rr_arbiter #(.REQ_WIDTH(4), .MAX_HOLD(0), .CNT_WIDTH(16)) u_dut0 (
    .ACLK(clk), .ARESETn(rstn), .req(req_i), .fixed_pri_en(fix_i), .done(done_i),
    .gnt(gnt0), .gnt_idx(idx0), .gnt_vld(vld0), .ptr(ptr0), .timeout(tmo0)
  );

  axi_rr_arbiter #(.REQ_WIDTH(4), .MAX_HOLD(8), .CNT_WIDTH(16)) u_dut8 (
    .ACLK(clk), .ARESETn(rstn), .req(req_i), .fixed_pri_en(fix_i), .done(done_i),
    .gnt(gnt8), .gnt_idx(idx8), .gnt_vld(vld8), .ptr(ptr8), .timeout(tmo8)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic [1:0] ptr;
    logic       tmo;
  } exp_t;

  exp_t q0[$];
  exp_t q8[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: owner = -1 when nothing is granted; hold = cycles elapsed in the current grant.
  int m_owner[2] = '{-1, -1};
  int m_idx[2]   = '{0, 0};
  int m_ptr[2]   = '{0, 0};
  int m_hold[2]  = '{0, 0};
  bit m_tmo[2]   = '{0, 0};

  function automatic int pick(logic [3:0] r, bit f, int p);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = f ? k : (p + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(int k, int mh, logic [3:0] r, bit f, bit d, bit n);
    int w;
    bit rel;
    if (!n) begin
      m_owner[k] = -1; m_idx[k] = 0; m_ptr[k] = 0; m_hold[k] = 0; m_tmo[k] = 0;
      return;
    end
    m_tmo[k] = 0;
    if (m_owner[k] < 0) begin
      w = pick(r, f, m_ptr[k]);
      if (w >= 0) begin m_owner[k] = w; m_idx[k] = w; m_hold[k] = 0; end
    end else begin
      rel = d || (mh != 0 && m_hold[k] == mh - 1);
      if (rel) begin
        m_tmo[k] = !d;
        if (!f) m_ptr[k] = (m_owner[k] + 1) % 4;
        w = pick(r, f, m_ptr[k]);
        if (w >= 0) begin m_owner[k] = w; m_idx[k] = w; m_hold[k] = 0; end
        else m_owner[k] = -1;
      end else begin
        m_hold[k]++;
      end
    end
  endtask

  function automatic exp_t model_out(int k);
    exp_t e;
    e.gnt = (m_owner[k] < 0) ? 4'b0000 : 4'(1 << m_owner[k]);
    e.idx = 2'(m_idx[k]);
    e.vld = (m_owner[k] >= 0);
    e.ptr = 2'(m_ptr[k]);
    e.tmo = m_tmo[k];
    return e;
  endfunction

  task automatic step(logic [3:0] r, bit f, bit d, bit n);
    req_i = r; fix_i = f; done_i = d; rstn = n;
    @(posedge clk);
    model_step(0, 0, r, f, d, n);
    model_step(1, 8, r, f, d, n);
    q0.push_back(model_out(0));
    q8.push_back(model_out(1));
    #1;
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0 && q8.size() > 0) begin
      exp_t e0, e8;
      e0 = q0.pop_front();
      e8 = q8.pop_front();
      check("gnt/mh0",     32'(gnt0), 32'(e0.gnt));
      check("gnt_idx/mh0", 32'(idx0), 32'(e0.idx));
      check("gnt_vld/mh0", 32'(vld0), 32'(e0.vld));
      check("ptr/mh0",     32'(ptr0), 32'(e0.ptr));
      check("timeout/mh0", 32'(tmo0), 32'(e0.tmo));
      check("gnt/mh8",     32'(gnt8), 32'(e8.gnt));
      check("gnt_idx/mh8", 32'(idx8), 32'(e8.idx));
      check("gnt_vld/mh8", 32'(vld8), 32'(e8.vld));
      check("ptr/mh8",     32'(ptr8), 32'(e8.ptr));
      check("timeout/mh8", 32'(tmo8), 32'(e8.tmo));
    end
  end

  initial begin
    // Reset with all requests pending, then first grant one cycle after release
    repeat (3) step(4'b1111, 1'b0, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0, 1'b1);
    // RR rotation, done on the 2nd cycle of each grant
    repeat (5) begin
      step(4'b1111, 1'b0, 1'b0, 1'b1);
      step(4'b1111, 1'b0, 1'b1, 1'b1);
    end
    // Walk to a grant of idx 2, then skip/wrap with req=0101
    step(4'b1111, 1'b0, 1'b1, 1'b1);
    step(4'b0101, 1'b0, 1'b1, 1'b1);
    step(4'b0101, 1'b0, 1'b0, 1'b1);
    step(4'b0101, 1'b0, 1'b1, 1'b1);
    step(4'b0101, 1'b0, 1'b0, 1'b1);
    // Fixed priority
    repeat (3) begin
      step(4'b1100, 1'b1, 1'b1, 1'b1);
      step(4'b1100, 1'b1, 1'b0, 1'b1);
    end
    step(4'b1000, 1'b1, 1'b1, 1'b1);
    step(4'b1000, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b1, 1'b1);
    // done while idle
    repeat (3) step(4'b0000, 1'b0, 1'b1, 1'b1);
    // Timeout on the MAX_HOLD=8 instance, re-grant on the same edge
    repeat (20) step(4'b0010, 1'b0, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b1, 1'b1);
    // Owner drops req mid-grant; mode toggle mid-grant
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    repeat (3) step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1, 1'b1);
    // Reset mid-grant
    step(4'b0100, 1'b0, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] r;
      bit f, d, n;
      r = 4'($urandom);
      f = ($urandom_range(0, 7) == 0) ? ~fix_i : fix_i;
      d = (c % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 14) == 0);
      n = ($urandom_range(0, 299) != 0);
      step(r, f, d, n);
    end
    step(4'b0000, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
